// File: rtl/coproc_host_ctrl.sv
// Host-side command sequencer for the homomorphic co-processor: runs one LOAD/EXEC/READ
// at a time, drives the per-unit address/write/reset pins, and returns one response per command.
module coproc_host_ctrl #(
    parameter int N       = 1024,
    parameter int AW      = 5,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 5,
    parameter int SCRATCH = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [1:0]      cmd_unit,
    input  logic [AW-1:0]   cmd_src1,
    input  logic [AW-1:0]   cmd_src2,
    input  logic [AW-1:0]   cmd_dst,
    input  logic [N-1:0]    cmd_data,
    output logic [3*AW-1:0] cp_adr1,
    output logic [3*AW-1:0] cp_adr2,
    output logic [3*AW-1:0] cp_adw,
    output logic [3*N-1:0]  cp_w_in,
    output logic            cp_write,
    output logic            cp_read_result,
    output logic            cp_rst_add1,
    output logic            cp_rst_mul,
    output logic            cp_rst_add2,
    input  logic [3*N-1:0]  cp_r_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_data,
    output logic            rsp_err
);

    localparam int CW = $clog2(MUL_LAT + 2);
    localparam logic [AW-1:0]   SCR  = AW'(SCRATCH);
    localparam logic [3*AW-1:0] SCR3 = {3{SCR}};

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, READ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    unit_q;
    logic [AW-1:0] src1_q, src2_q, dst_q;
    logic          illegal;
    logic [CW-1:0] lat;

    always_comb begin
        illegal = (cmd_op == 2'b11) || (cmd_unit == 2'b11) ||
                  ((cmd_op != 2'b10) && (cmd_dst == SCR));
        lat     = (cmd_unit == 2'd1) ? CW'(MUL_LAT) : CW'(ADD_LAT);
    end

    // Every co-processor pin falls back to its parked value each cycle unless the
    // current phase overrides the lane of the active unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            cp_adr1        <= SCR3;
            cp_adr2        <= SCR3;
            cp_adw         <= SCR3;
            cp_w_in        <= '0;
            cp_write       <= 1'b0;
            cp_read_result <= 1'b0;
            cp_rst_add1    <= 1'b1;
            cp_rst_mul     <= 1'b1;
            cp_rst_add2    <= 1'b1;
        end else begin
            cp_adr1        <= SCR3;
            cp_adr2        <= SCR3;
            cp_adw         <= SCR3;
            cp_w_in        <= '0;
            cp_write       <= 1'b0;
            cp_read_result <= 1'b0;
            cp_rst_add1    <= 1'b1;
            cp_rst_mul     <= 1'b1;
            cp_rst_add2    <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        unit_q    <= cmd_unit;
                        src1_q    <= cmd_src1;
                        src2_q    <= cmd_src2;
                        dst_q     <= cmd_dst;
                        if (illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (cmd_op == 2'b00) begin
                            state    <= LOAD;
                            cnt      <= CW'(1);
                            cp_write <= 1'b1;
                            cp_w_in[int'(cmd_unit)*N +: N] <= cmd_data;
                        end else begin
                            state <= (cmd_op == 2'b10) ? READ : EXEC;
                            cnt   <= lat;
                            cp_adr1[int'(cmd_unit)*AW +: AW] <= cmd_src1;
                            cp_adr2[int'(cmd_unit)*AW +: AW] <= cmd_src2;
                            cp_read_result <= (cmd_op == 2'b10) && (lat == CW'(1));
                            case (cmd_unit)
                                2'd0:    cp_rst_add1 <= 1'b0;
                                2'd1:    cp_rst_mul  <= 1'b0;
                                default: cp_rst_add2 <= 1'b0;
                            endcase
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt != '0) begin
                        cp_adw[int'(unit_q)*AW +: AW] <= dst_q;
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                    end
                end
                EXEC, READ: begin
                    // cnt > 1: operand hold; cnt == 1: write-back slot; cnt == 0: respond
                    if (cnt > CW'(1)) begin
                        cp_adr1[int'(unit_q)*AW +: AW] <= src1_q;
                        cp_adr2[int'(unit_q)*AW +: AW] <= src2_q;
                        cp_read_result <= (state == READ) && (cnt == CW'(2));
                        case (unit_q)
                            2'd0:    cp_rst_add1 <= 1'b0;
                            2'd1:    cp_rst_mul  <= 1'b0;
                            default: cp_rst_add2 <= 1'b0;
                        endcase
                        cnt <= cnt - CW'(1);
                    end else if (cnt == CW'(1)) begin
                        if (state == EXEC) cp_adw[int'(unit_q)*AW +: AW] <= dst_q;
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (state == READ) rsp_data <= cp_r_out[int'(unit_q)*N +: N];
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_host_ctrl.sv
// Directed bench for coproc_host_ctrl: cycle-exact checks of LOAD/EXEC/READ, illegal
// commands, response backpressure and mid-command reset.
module tb_coproc_host_ctrl;

    localparam int N  = 1024;
    localparam int AW = 5;
    localparam logic [3*AW-1:0] SCR3 = {3{5'd31}};

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [1:0]      cmd_unit;
    logic [AW-1:0]   cmd_src1, cmd_src2, cmd_dst;
    logic [N-1:0]    cmd_data;
    logic [3*AW-1:0] cp_adr1, cp_adr2, cp_adw;
    logic [3*N-1:0]  cp_w_in;
    logic            cp_write, cp_read_result;
    logic            cp_rst_add1, cp_rst_mul, cp_rst_add2;
    logic [3*N-1:0]  cp_r_out;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [N-1:0]    rsp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    coproc_host_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_unit(cmd_unit),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
        .cp_adr1(cp_adr1), .cp_adr2(cp_adr2), .cp_adw(cp_adw), .cp_w_in(cp_w_in),
        .cp_write(cp_write), .cp_read_result(cp_read_result),
        .cp_rst_add1(cp_rst_add1), .cp_rst_mul(cp_rst_mul), .cp_rst_add2(cp_rst_add2),
        .cp_r_out(cp_r_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3*AW-1:0] lane_set(input int u, input logic [AW-1:0] v);
        logic [3*AW-1:0] r;
        r = SCR3;
        r[u*AW +: AW] = v;
        return r;
    endfunction

    // Offer a command, wait (bounded) for cmd_ready, and return in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [1:0] unit, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [AW-1:0] dst, input logic [N-1:0] data);
        int i;
        cmd_valid = 1'b1; cmd_op = op; cmd_unit = unit;
        cmd_src1 = s1; cmd_src2 = s2; cmd_dst = dst; cmd_data = data;
        i = 0;
        while (cmd_ready !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, i);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, cp_write, cp_read_result} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/vld/err/wr/rr=%b required 00000",
                     {cmd_ready, rsp_valid, rsp_err, cp_write, cp_read_result});
        end
        checks++;
        if ({cp_rst_add2, cp_rst_mul, cp_rst_add1} !== 3'b111) begin
            errors++;
            $display("FAIL reset_cprst: %b required 111", {cp_rst_add2, cp_rst_mul, cp_rst_add1});
        end
        checks++;
        if ({cp_adr1, cp_adr2, cp_adw} !== {SCR3, SCR3, SCR3}) begin
            errors++;
            $display("FAIL reset_addr: adr1=%h adr2=%h adw=%h required %h", cp_adr1, cp_adr2, cp_adw, SCR3);
        end
        checks++;
        if (cp_w_in !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: w_in/rsp_data not zero (rsp_data low=%h)", rsp_data[63:0]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_load;
        logic [3*N-1:0] ew;
        rsp_ready = 1'b1;
        issue(2'b00, 2'd0, 5'd0, 5'd0, 5'd4, N'(32'h0000_1234));
        ew = '0;
        ew[31:0] = 32'h0000_1234;
        checks++;
        if (cp_write !== 1'b1 || cp_w_in !== ew || cp_adw !== SCR3) begin
            errors++;
            $display("FAIL load_t1: write=%b lane0=%h adw=%h required 1 00001234 %h",
                     cp_write, cp_w_in[31:0], cp_adw, SCR3);
        end
        tick();
        checks++;
        if (cp_write !== 1'b0 || cp_w_in !== '0 || cp_adw !== lane_set(0, 5'd4) || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_t2: write=%b adw=%h vld=%b required 0 %h 0",
                     cp_write, cp_adw, rsp_valid, lane_set(0, 5'd4));
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== '0 || cp_adw !== SCR3) begin
            errors++;
            $display("FAIL load_t3: vld=%b err=%b data_lo=%h adw=%h required 1 0 0 %h",
                     rsp_valid, rsp_err, rsp_data[63:0], cp_adw, SCR3);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_t4: vld=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_exec;
        rsp_ready = 1'b1;
        issue(2'b01, 2'd2, 5'd4, 5'd5, 5'd6, '0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (cp_adr1 !== ((k <= 2) ? lane_set(2, 5'd4) : SCR3) ||
                cp_adr2 !== ((k <= 2) ? lane_set(2, 5'd5) : SCR3)) begin
                errors++;
                $display("FAIL exec_addr T+%0d: adr1=%h adr2=%h", k, cp_adr1, cp_adr2);
            end
            checks++;
            if ({cp_rst_add2, cp_rst_mul, cp_rst_add1} !== ((k <= 2) ? 3'b011 : 3'b111)) begin
                errors++;
                $display("FAIL exec_cprst T+%0d: %b required %b", k,
                         {cp_rst_add2, cp_rst_mul, cp_rst_add1}, (k <= 2) ? 3'b011 : 3'b111);
            end
            checks++;
            if (cp_adw !== ((k == 3) ? lane_set(2, 5'd6) : SCR3) || rsp_valid !== (k == 4)) begin
                errors++;
                $display("FAIL exec_wb_rsp T+%0d: adw=%h vld=%b", k, cp_adw, rsp_valid);
            end
            if (k == 4) begin
                checks++;
                if (rsp_err !== 1'b0 || rsp_data !== '0) begin
                    errors++;
                    $display("FAIL exec_rsp_fields: err=%b data_lo=%h required 0 0", rsp_err, rsp_data[63:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_read;
        logic [N-1:0] ed;
        rsp_ready = 1'b1;
        issue(2'b10, 2'd1, 5'd6, 5'd7, 5'd0, '0);
        ed = '0;
        ed[31:0] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 8; k++) begin
            cp_r_out = '0;
            cp_r_out[31:0]      = 32'hAAAA_0000;
            cp_r_out[N +: 32]   = (k == 6) ? 32'hDEAD_BEEF : (32'h1111_0000 | 32'(k));
            cp_r_out[2*N +: 32] = 32'hBBBB_0000;
            checks++;
            if (cp_adr1 !== ((k <= 5) ? lane_set(1, 5'd6) : SCR3) ||
                cp_adr2 !== ((k <= 5) ? lane_set(1, 5'd7) : SCR3) || cp_adw !== SCR3 ||
                {cp_rst_add2, cp_rst_mul, cp_rst_add1} !== ((k <= 5) ? 3'b101 : 3'b111)) begin
                errors++;
                $display("FAIL read_addr T+%0d: adr1=%h adr2=%h adw=%h rst=%b", k, cp_adr1, cp_adr2,
                         cp_adw, {cp_rst_add2, cp_rst_mul, cp_rst_add1});
            end
            checks++;
            if (cp_read_result !== (k == 5) || rsp_valid !== (k == 7)) begin
                errors++;
                $display("FAIL read_timing T+%0d: rr=%b vld=%b required %b %b", k, cp_read_result,
                         rsp_valid, (k == 5), (k == 7));
            end
            if (k == 7) begin
                checks++;
                if (rsp_data !== ed || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL read_data: data_lo=%h err=%b required deadbeef 0", rsp_data[63:0], rsp_err);
                end
            end
            tick();
        end
        cp_r_out = '0;
    endtask

    task automatic test_illegal;
        logic [1:0]    ops [3] = '{2'b01, 2'b01, 2'b11};
        logic [1:0]    uns [3] = '{2'd3, 2'd0, 2'd1};
        logic [AW-1:0] dsts[3] = '{5'd6, 5'd31, 5'd6};
        rsp_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            issue(ops[v], uns[v], 5'd1, 5'd2, dsts[v], N'(32'h55));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
                errors++;
                $display("FAIL illegal_rsp v%0d: vld=%b err=%b data_lo=%h required 1 1 0",
                         v, rsp_valid, rsp_err, rsp_data[63:0]);
            end
            checks++;
            if ({cp_adr1, cp_adr2, cp_adw} !== {SCR3, SCR3, SCR3} || cp_write !== 1'b0 ||
                cp_w_in !== '0 || {cp_rst_add2, cp_rst_mul, cp_rst_add1} !== 3'b111) begin
                errors++;
                $display("FAIL illegal_cp v%0d: adr1=%h adw=%h wr=%b", v, cp_adr1, cp_adw, cp_write);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL illegal_done v%0d: vld=%b err=%b required 0 0", v, rsp_valid, rsp_err);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0]   ed;
        logic [3*N-1:0] ew;
        int bad;
        ed = '0;
        ed[31:0] = 32'hCAFE_F00D;
        cp_r_out = '0;
        cp_r_out[31:0] = 32'hCAFE_F00D;
        rsp_ready = 1'b0;
        issue(2'b10, 2'd0, 5'd2, 5'd3, 5'd0, '0);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_early: vld=%b at T+3 required 0", rsp_valid);
        end
        tick();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_unit = 2'd1; cmd_dst = 5'd3; cmd_data = N'(32'h77);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles required 0 (vld=%b rdy=%b)", bad, rsp_valid, cmd_ready);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: vld=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        ew = '0;
        ew[N +: 32] = 32'h77;
        checks++;
        if (cp_write !== 1'b1 || cp_w_in !== ew) begin
            errors++;
            $display("FAIL b2b_write: wr=%b lane1=%h required 1 00000077", cp_write, cp_w_in[N +: 32]);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL b2b_rsp: vld=%b err=%b required 1 0", rsp_valid, rsp_err);
        end
        tick();
        cp_r_out = '0;
    endtask

    task automatic test_rst_abort;
        int bad;
        rsp_ready = 1'b1;
        issue(2'b01, 2'd1, 5'd1, 5'd2, 5'd3, '0);
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (cp_adr1 !== SCR3 || cp_adr2 !== SCR3 || cp_adw !== SCR3 ||
            {cp_rst_add2, cp_rst_mul, cp_rst_add1} !== 3'b111 ||
            {cmd_ready, rsp_valid, rsp_err, cp_write, cp_read_result} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_reset_vals: adr1=%h rst=%b ctrl=%b", cp_adr1,
                     {cp_rst_add2, cp_rst_mul, cp_rst_add1},
                     {cmd_ready, rsp_valid, rsp_err, cp_write, cp_read_result});
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (cp_adw !== SCR3 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_wb: %0d cycles with adw/rsp activity required 0", bad);
        end
        issue(2'b00, 2'd1, 5'd0, 5'd0, 5'd8, N'(32'hAB));
        checks++;
        if (cp_write !== 1'b1 || cp_w_in[N +: N] !== N'(32'hAB)) begin
            errors++;
            $display("FAIL abort_next_write: wr=%b lane1=%h required 1 000000ab", cp_write, cp_w_in[N +: 32]);
        end
        tick();
        checks++;
        if (cp_adw !== lane_set(1, 5'd8)) begin
            errors++;
            $display("FAIL abort_next_adw: adw=%h required %h", cp_adw, lane_set(1, 5'd8));
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_rsp: vld=%b err=%b required 1 0", rsp_valid, rsp_err);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_unit = '0;
        cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_data = '0;
        cp_r_out = '0; rsp_ready = 1'b0;
        test_reset();
        test_load();
        test_exec();
        test_read();
        test_illegal();
        test_back_to_back();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
